// File: rtl/inst_queue.sv
// Instruction queue feeding the Tomasulo issue stage; serves one instruction per request edge.
// Optional INST_QUEUE_BYPASS_EN forwards a push straight to the outputs while a request waits on an empty queue.
module inst_queue #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_push,
   input  logic [5:0]        in_operator_type,
   input  logic [4:0]        in_reg_1,
   input  logic [4:0]        in_reg_2,
   input  logic [4:0]        in_reg_3,
   input  logic [3:0]        in_ICC_flags,
   input  logic              in_fetch_req,
   input  logic              in_flush,
   output logic              out_fetch_next,
   output logic [5:0]        out_operator_type,
   output logic [4:0]        out_reg_1,
   output logic [4:0]        out_reg_2,
   output logic [4:0]        out_reg_3,
   output logic [3:0]        out_ICC_flags,
   output logic              out_full,
   output logic              out_empty,
   output logic [ADDR_W:0]   out_count,
   output logic              out_overflow
);

   localparam int ENT_W = 25;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DELIVER} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W:0]    head_q, head_d, tail_q, tail_d, count;
   logic [ENT_W-1:0]   mem_q [DEPTH];
   logic [ENT_W-1:0]   mem_d [DEPTH];
   logic [ENT_W-1:0]   out_q, out_d, wr_data;
   logic               fetch_q, fetch_d;
   logic               req_q, req_d;
   logic               pending_q, pending_d;
   logic               ovf_q, ovf_d;
   logic               req_rise, pop, bypass;

   assign req_rise  = in_fetch_req & ~req_q;
   assign count     = tail_q - head_q;
   assign out_full  = (count == DEPTH_C);
   assign out_empty = (head_q == tail_q);
   assign out_count = count;
   assign out_overflow   = ovf_q;
   assign out_fetch_next = fetch_q;
   assign {out_operator_type, out_reg_1, out_reg_2, out_reg_3, out_ICC_flags} = out_q;

   always_comb begin
      wr_data   = {in_operator_type, in_reg_1, in_reg_2, in_reg_3, in_ICC_flags};
      state_d   = state_q;
      head_d    = head_q;
      tail_d    = tail_q;
      mem_d     = mem_q;
      out_d     = out_q;
      fetch_d   = 1'b0;
      req_d     = in_fetch_req;
      pending_d = pending_q | req_rise;
      ovf_d     = ovf_q;
      pop       = 1'b0;
      bypass    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_rise || pending_q) begin
               pending_d = 1'b0;
               state_d   = (count != '0) ? S_DELIVER : S_WAIT;
            end
         end
         S_WAIT: begin
`ifdef INST_QUEUE_BYPASS_EN
            if (in_push && count == '0) begin
               bypass  = 1'b1;
               out_d   = wr_data;
               fetch_d = 1'b1;
               state_d = S_IDLE;
            end else
`endif
            // A push on this edge lands in the buffer, so delivery can follow next cycle.
            if (count != '0 || in_push) state_d = S_DELIVER;
         end
         S_DELIVER: begin
            pop     = 1'b1;
            out_d   = mem_q[head_q[ADDR_W-1:0]];
            fetch_d = 1'b1;
            head_d  = head_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A simultaneous pop frees the slot a push into a full queue needs.
      if (in_push && !bypass) begin
         if (!out_full || pop) begin
            mem_d[tail_q[ADDR_W-1:0]] = wr_data;
            tail_d = tail_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end

      if (in_flush) begin
         head_d    = '0;
         tail_d    = '0;
         state_d   = S_IDLE;
         pending_d = 1'b0;
         fetch_d   = 1'b0;
         out_d     = out_q;
         mem_d     = mem_q;
         ovf_d     = ovf_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         head_q    <= '0;
         tail_q    <= '0;
         out_q     <= '0;
         fetch_q   <= 1'b0;
         req_q     <= 1'b0;
         pending_q <= 1'b0;
         ovf_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         out_q     <= out_d;
         fetch_q   <= fetch_d;
         req_q     <= req_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus a randomized run against a queue model.
module tb_inst_queue;

   logic        clk, rst;
   logic        in_push, in_fetch_req, in_flush;
   logic [5:0]  in_operator_type;
   logic [4:0]  in_reg_1, in_reg_2, in_reg_3;
   logic [3:0]  in_ICC_flags;
   logic        out_fetch_next, out_full, out_empty, out_overflow;
   logic [5:0]  out_operator_type;
   logic [4:0]  out_reg_1, out_reg_2, out_reg_3;
   logic [3:0]  out_ICC_flags;
   logic [3:0]  out_count;
   logic [24:0] out_all;

   int checks = 0;
   int errors = 0;

   inst_queue #(.DEPTH(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .in_push(in_push),
      .in_operator_type(in_operator_type), .in_reg_1(in_reg_1), .in_reg_2(in_reg_2),
      .in_reg_3(in_reg_3), .in_ICC_flags(in_ICC_flags), .in_fetch_req(in_fetch_req),
      .in_flush(in_flush), .out_fetch_next(out_fetch_next),
      .out_operator_type(out_operator_type), .out_reg_1(out_reg_1), .out_reg_2(out_reg_2),
      .out_reg_3(out_reg_3), .out_ICC_flags(out_ICC_flags), .out_full(out_full),
      .out_empty(out_empty), .out_count(out_count), .out_overflow(out_overflow)
   );

   assign out_all = {out_operator_type, out_reg_1, out_reg_2, out_reg_3, out_ICC_flags};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_push(input logic [24:0] d);
      {in_operator_type, in_reg_1, in_reg_2, in_reg_3, in_ICC_flags} = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_push = 1'b0; in_fetch_req = 1'b0; in_flush = 1'b0;
      set_push(25'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_fetch_next !== 1'b0) begin errors++; $display("FAIL reset_fetch: got %b exp 0", out_fetch_next); end
      checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", out_empty); end
      checks++; if (out_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", out_full); end
      checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", out_count); end
      checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", out_overflow); end
      checks++; if (out_all !== 25'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", out_all); end
   endtask

   task automatic test_deliver();
      logic [24:0] e;
      e = {6'b001010, 5'd0, 5'd1, 5'd2, 4'b0101};
      set_push(e); in_push = 1'b1; tick(); in_push = 1'b0;
      in_fetch_req = 1'b1; tick();
      checks++; if (out_fetch_next !== 1'b0) begin errors++; $display("FAIL deliver_early: got %b exp 0", out_fetch_next); end
      tick();
      checks++; if (out_fetch_next !== 1'b1) begin errors++; $display("FAIL deliver_strobe: got %b exp 1", out_fetch_next); end
      checks++; if (out_all !== e) begin errors++; $display("FAIL deliver_data: got %h exp %h", out_all, e); end
      checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL deliver_count: got %0d exp 0", out_count); end
      tick();
      checks++; if (out_fetch_next !== 1'b0) begin errors++; $display("FAIL deliver_strobe_low: got %b exp 0", out_fetch_next); end
      checks++; if (out_all !== e) begin errors++; $display("FAIL deliver_hold: got %h exp %h", out_all, e); end
      in_fetch_req = 1'b0; tick();
   endtask

   task automatic test_wait();
      logic [24:0] e;
      e = {6'b001000, 5'd0, 5'd3, 5'd7, 4'b1000};
      in_fetch_req = 1'b1; tick(); tick();
      checks++; if (out_fetch_next !== 1'b0) begin errors++; $display("FAIL wait_nostrobe: got %b exp 0", out_fetch_next); end
      set_push(e); in_push = 1'b1; tick(); in_push = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      checks++; if (out_fetch_next !== 1'b1) begin errors++; $display("FAIL wait_bypass_strobe: got %b exp 1", out_fetch_next); end
      checks++; if (out_all !== e) begin errors++; $display("FAIL wait_bypass_data: got %h exp %h", out_all, e); end
      checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL wait_bypass_count: got %0d exp 0", out_count); end
`else
      checks++; if (out_fetch_next !== 1'b0) begin errors++; $display("FAIL wait_push_edge: got %b exp 0", out_fetch_next); end
      checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL wait_push_count: got %0d exp 1", out_count); end
      tick();
      checks++; if (out_fetch_next !== 1'b1) begin errors++; $display("FAIL wait_strobe: got %b exp 1", out_fetch_next); end
      checks++; if (out_all !== e) begin errors++; $display("FAIL wait_data: got %h exp %h", out_all, e); end
      checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL wait_count: got %0d exp 0", out_count); end
`endif
      in_fetch_req = 1'b0; tick();
      checks++; if (out_fetch_next !== 1'b0) begin errors++; $display("FAIL wait_after: got %b exp 0", out_fetch_next); end
   endtask

   task automatic test_overflow();
      logic [24:0] ent [9];
      logic [24:0] expl [8];
      logic [24:0] nw;
      for (int i = 0; i < 9; i++) ent[i] = 25'($urandom);
      for (int i = 0; i < 8; i++) begin set_push(ent[i]); in_push = 1'b1; tick(); end
      checks++; if (out_full !== 1'b1 || out_count !== 4'd8) begin errors++; $display("FAIL ovf_full: got full=%b count=%0d exp full=1 count=8", out_full, out_count); end
      checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", out_overflow); end
      set_push(ent[8]); tick(); in_push = 1'b0;
      checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", out_overflow); end
      checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d exp 8", out_count); end
      in_fetch_req = 1'b1; tick();
      nw = 25'($urandom); set_push(nw); in_push = 1'b1; tick(); in_push = 1'b0;
      checks++; if (out_fetch_next !== 1'b1 || out_all !== ent[0]) begin errors++; $display("FAIL pushpop_deliver: got strobe=%b data=%h exp 1 %h", out_fetch_next, out_all, ent[0]); end
      checks++; if (out_count !== 4'd8 || out_full !== 1'b1) begin errors++; $display("FAIL pushpop_count: got %0d exp 8", out_count); end
      for (int i = 0; i < 7; i++) expl[i] = ent[i+1];
      expl[7] = nw;
      for (int i = 0; i < 8; i++) begin
         in_fetch_req = 1'b0; tick(); in_fetch_req = 1'b1; tick(); tick();
         checks++; if ({out_fetch_next, out_all} !== {1'b1, expl[i]}) begin errors++; $display("FAIL drain_%0d: got strobe=%b data=%h exp 1 %h", i, out_fetch_next, out_all, expl[i]); end
      end
      checks++; if (out_empty !== 1'b1 || out_overflow !== 1'b1) begin errors++; $display("FAIL drain_end: got empty=%b ovf=%b exp 1 1", out_empty, out_overflow); end
      in_fetch_req = 1'b0; tick();
      do_reset();
      checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", out_overflow); end
   endtask

   task automatic test_hold();
      logic [24:0] h [3];
      logic [24:0] got;
      int strobes;
      for (int i = 0; i < 3; i++) begin h[i] = 25'($urandom); set_push(h[i]); in_push = 1'b1; tick(); end
      in_push = 1'b0;
      in_fetch_req = 1'b1; strobes = 0; got = '0;
      repeat (5) begin tick(); if (out_fetch_next) begin strobes++; got = out_all; end end
      checks++; if (strobes != 1) begin errors++; $display("FAIL hold_strobes: got %0d exp 1", strobes); end
      checks++; if (got !== h[0]) begin errors++; $display("FAIL hold_data: got %h exp %h", got, h[0]); end
      checks++; if (out_count !== 4'd2) begin errors++; $display("FAIL hold_count: got %0d exp 2", out_count); end
      in_fetch_req = 1'b0; tick(); in_fetch_req = 1'b1; tick(); tick();
      checks++; if ({out_fetch_next, out_all} !== {1'b1, h[1]}) begin errors++; $display("FAIL hold_second: got strobe=%b data=%h exp 1 %h", out_fetch_next, out_all, h[1]); end
      in_fetch_req = 1'b0; tick();
   endtask

   task automatic test_flush();
      logic [24:0] last;
      last = out_all;
      for (int i = 0; i < 3; i++) begin set_push(25'($urandom)); in_push = 1'b1; tick(); end
      in_push = 1'b0;
      in_fetch_req = 1'b1; in_flush = 1'b1; tick(); in_flush = 1'b0;
      checks++; if (out_fetch_next !== 1'b0) begin errors++; $display("FAIL flush_strobe: got %b exp 0", out_fetch_next); end
      checks++; if (out_count !== 4'd0 || out_empty !== 1'b1) begin errors++; $display("FAIL flush_count: got count=%0d empty=%b exp 0 1", out_count, out_empty); end
      checks++; if (out_all !== last) begin errors++; $display("FAIL flush_hold: got %h exp %h", out_all, last); end
      set_push(25'($urandom)); in_push = 1'b1; tick(); in_push = 1'b0; tick(); tick();
      checks++; if (out_fetch_next !== 1'b0 || out_count !== 4'd1) begin errors++; $display("FAIL flush_req_dropped: got strobe=%b count=%0d exp 0 1", out_fetch_next, out_count); end
      in_fetch_req = 1'b0; tick();
   endtask

   task automatic test_reset_mid();
      in_fetch_req = 1'b1; tick(); tick();
      checks++; if (out_fetch_next !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b exp 1", out_fetch_next); end
      rst = 1'b1; #1;
      checks++; if (out_fetch_next !== 1'b0 || out_all !== 25'd0) begin errors++; $display("FAIL rstmid_drop: got strobe=%b data=%h exp 0 0", out_fetch_next, out_all); end
      checks++; if (out_empty !== 1'b1 || out_count !== 4'd0) begin errors++; $display("FAIL rstmid_empty: got empty=%b count=%0d exp 1 0", out_empty, out_count); end
      @(negedge clk);
      in_fetch_req = 1'b0; rst = 1'b0;
   endtask

   task automatic test_random();
      logic [24:0] mq [$];
      logic [24:0] exp_out, d;
      logic        exp_ovf, prev_req, deliver, popped, bp, rise;
      int          exp_edge, rise_edge, pre_size;
      bit          waiting, outstanding;
      do_reset();
      exp_out = '0; exp_ovf = 1'b0; prev_req = 1'b0;
      exp_edge = -1; rise_edge = -1; waiting = 0; outstanding = 0;
      for (int e = 1; e <= 800; e++) begin
         // Requester: never raises while a request is still unserved.
         if (outstanding) begin
            if ($urandom_range(3) == 0) in_fetch_req = 1'b0;
         end else if (in_fetch_req) begin
            if ($urandom_range(1) == 0) in_fetch_req = 1'b0;
         end else if ($urandom_range(2) == 0) in_fetch_req = 1'b1;
         rise = in_fetch_req & ~prev_req;
         prev_req = in_fetch_req;
         in_push = ($urandom_range(4) < 2);
         d = 25'($urandom);
         set_push(d);

         pre_size = mq.size();
         deliver = 1'b0; popped = 1'b0; bp = 1'b0;
         if (rise) begin
            outstanding = 1;
            if (pre_size > 0) exp_edge = e + 1;
            else begin waiting = 1; rise_edge = e; end
         end
         if (waiting && in_push) begin
            waiting = 0;
            if (e == rise_edge) exp_edge = e + 2;
            else begin
`ifdef INST_QUEUE_BYPASS_EN
               bp = 1'b1; deliver = 1'b1; exp_out = d; outstanding = 0; exp_edge = -1;
`else
               exp_edge = e + 1;
`endif
            end
         end
         if (outstanding && exp_edge == e) begin
            deliver = 1'b1; popped = 1'b1; exp_out = mq.pop_front(); outstanding = 0;
         end
         if (in_push && !bp) begin
            if (pre_size < 8 || popped) mq.push_back(d);
            else exp_ovf = 1'b1;
         end

         tick();
         checks++; if (out_fetch_next !== deliver) begin errors++; $display("FAIL rnd_strobe@%0d: got %b exp %b", e, out_fetch_next, deliver); end
         checks++; if (out_all !== exp_out) begin errors++; $display("FAIL rnd_data@%0d: got %h exp %h", e, out_all, exp_out); end
         checks++; if (out_count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d exp %0d", e, out_count, mq.size()); end
         checks++; if (out_full !== (mq.size() == 8) || out_empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_flags@%0d: got full=%b empty=%b size=%0d", e, out_full, out_empty, mq.size()); end
         checks++; if (out_overflow !== exp_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %b exp %b", e, out_overflow, exp_ovf); end
      end
      in_push = 1'b0; in_fetch_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_deliver();
      test_wait();
      test_overflow();
      test_hold();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue that feeds the Tomasulo issue stage. Decoded instructions are pushed in program order from the fetch/decode side. The queue answers the current-instruction unit's fetch request by presenting the next instruction's operator type, register fields and ICC flags, together with a one-cycle fetch strobe. It is the supplier end of the CUR_INST fetch handshake: its outputs drive CUR_INST `in_fetch_next`, `in_operator_type`, `in_reg_1..3` and `in_ICC_flags`.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥2.
- `ADDR_W`, 3: log2(DEPTH).
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_push`  in  1  write one instruction this cycle.
- `in_operator_type`  in  6  SPARC op3 (e.g. UMUL 6'b001010, ADD 6'b000000, ADDX 6'b001000).
- `in_reg_1`, `in_reg_2`, `in_reg_3`  in  5 each  source 1, source 2, destination.
- `in_ICC_flags`  in  4  NZVC snapshot carried with the instruction.
- `in_fetch_req`  in  1  level request from CUR_INST `out_fetch_next`.
- `in_flush`  in  1  synchronous discard of all entries and any pending request.
- `out_fetch_next`  out  1  one-cycle delivery strobe.
- `out_operator_type`  out  6; `out_reg_1/2/3`  out  5 each; `out_ICC_flags`  out  4  delivered instruction; held until the next delivery.
- `out_full`, `out_empty`  out  1  occupancy flags.
- `out_count`  out  ADDR_W+1  occupancy.
- `out_overflow`  out  1  sticky: a push was dropped.

## Operation
- Circular buffer with head/tail pointers of ADDR_W+1 bits. Pointers wrap at DEPTH; the MSB distinguishes full from empty.
- Request detection: `req_rise = in_fetch_req & ~req_q`, where `req_q` is registered. A rise sets `pending`. Each rise is served exactly once; a held-high level is not re-served.
- FSM:
  - IDLE: on `req_rise` with count>0 → DELIVER; on `req_rise` with count==0 → WAIT.
  - WAIT: when count>0 → DELIVER.
  - DELIVER: one cycle. Outputs are loaded from head, `out_fetch_next`=1, head++, then → IDLE.
- In DELIVER the strobe and the new fields appear together, registered on the same edge.
- Push while not full: writes at tail, tail++.
- Push while full and no pop on the same edge: data dropped, `out_overflow` set. It clears only on reset.
- Push and pop on the same edge: both happen. When full, the push is accepted because the pop frees a slot. Count is unchanged.
- `in_flush`: head=tail=0, FSM → IDLE, pending cleared, `out_fetch_next`=0. Data outputs hold their last values. Flush takes priority over a simultaneous push, pop or `req_rise`.
- `req_rise` arriving in DELIVER is latched as pending and served from IDLE on the following cycle.
- `out_full`, `out_empty` and `out_count` are derived combinationally from the pointers.

## Timing
- Reset values: all data outputs 0, `out_fetch_next`=0, `out_empty`=1, `out_full`=0, `out_count`=0, `out_overflow`=0, FSM IDLE, `req_q`=0.
- Reset mid-delivery aborts the strobe immediately (asynchronous).
- Non-empty queue: `req_rise` sampled at edge n → strobe and fields valid at edge n+1 (1-cycle latency). Strobe deasserts at edge n+2.
- Empty queue: request pending, then push at edge k → write at k, delivery at edge k+1.
- Back-to-back service needs the requester to drop and re-raise `in_fetch_req`. Minimum spacing is 2 cycles per instruction.

## Configuration
- `INST_QUEUE_BYPASS_EN`
  - Defined: in WAIT, a push on edge k is forwarded straight to the outputs with `out_fetch_next`=1 on edge k. The entry is not written and the pointers are unchanged.
  - Undefined: the 2-edge path above applies.
  - The bypass is never taken when count>0, so order is preserved.

## Test plan
- Reset, then push UMUL r0,r1→r2. Raise req at edge 3 → at edge 4 `out_fetch_next`=1, `out_operator_type`=6'b001010, `out_reg_3`=2. Count back to 0 and strobe low at edge 5.
- Raise req with the queue empty, then push ADDX r0,r3→r7, ICC=4'b1000. Without the macro, the strobe comes 1 cycle after the push; with the macro, on the push edge. Fields match in both cases.
- Push 8 entries (`out_full`=1), then push a 9th → `out_overflow`=1 and count stays 8. Then push and pop on the same edge → count 8 and the new entry is accepted.
- Hold req high for 5 cycles with 3 entries queued → exactly one delivery. Drop and re-raise → second entry delivered in order.
- Push 3 entries, assert `in_flush` together with `req_rise` → no strobe, count 0, `out_empty`=1, outputs hold their last values.
- Assert `rst` in the DELIVER cycle → strobe and outputs drop to 0 immediately and the queue is empty.
